// File: rtl/timer_req_sched_if.sv
// Avalon-MM register port between timer_req_sched (master) and the
// 16-bit interval timer slave (s1).
interface timer_req_sched_if;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/timer_req_sched.sv
// timer_req_sched: shares one interval timer among NUM_REQ one-shot
// timeout requesters using round-robin arbitration.
// Optional macro TIMER_SCHED_REMAIN_EN adds a remaining-count snapshot
// on the cancel path and the remaining_o output.
module timer_req_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [32*NUM_REQ-1:0]  ticks_i,
    output logic [NUM_REQ-1:0]     done_o,
    output logic [NUM_REQ-1:0]     cancelled_o,
    output logic                   busy_o,
    output logic [IDX_W-1:0]       owner_o,
    timer_req_sched_if.master      tmr
`ifdef TIMER_SCHED_REMAIN_EN
    ,
    output logic [31:0]            remaining_o
`endif
);

    typedef enum logic [3:0] {
        S_IDLE, S_WP0, S_WP1, S_WP2, S_WP3, S_WCTL, S_WAIT,
        S_CLR_D, S_FIN_D, S_WSTOP, S_CLR_C, S_FIN_C
`ifdef TIMER_SCHED_REMAIN_EN
        , S_SNAPW, S_SNAPR0, S_SNAPR1, S_SNAPC
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_q, rr_d;
    logic [31:0]          period_q, period_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic [NUM_REQ-1:0]   canc_q, canc_d;
    logic                 busy_q, busy_d;
    logic [3:0]           addr_q, addr_d;
    logic                 cs_q, cs_d;
    logic                 wn_q, wn_d;
    logic [15:0]          wd_q, wd_d;

    logic                 found;
    logic [IDX_W-1:0]     gnt;
    int unsigned          cand;
    logic [31:0]          tk;

`ifdef TIMER_SCHED_REMAIN_EN
    logic [31:0]          rem_q, rem_d;
`endif

    // State and registered outputs; reset_n also resets the timer, so no cleanup
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            period_q <= '0;
            done_q   <= '0;
            canc_q   <= '0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            cs_q     <= 1'b0;
            wn_q     <= 1'b1;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            period_q <= period_d;
            done_q   <= done_d;
            canc_q   <= canc_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            cs_q     <= cs_d;
            wn_q     <= wn_d;
            wd_q     <= wd_d;
        end
    end

    // Next state: round-robin grant in IDLE, fixed programming/cleanup sequences
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        period_d = period_q;
        found    = 1'b0;
        gnt      = '0;
        cand     = 0;
        tk       = '0;
        case (state_q)
            S_IDLE: begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = (32'(rr_q) + k) % NUM_REQ;
                    if (!found && req_i[cand]) begin
                        found = 1'b1;
                        gnt   = IDX_W'(cand);
                    end
                end
                if (found) begin
                    owner_d  = gnt;
                    tk       = ticks_i[32*int'(gnt) +: 32];
                    period_d = (tk == '0) ? '0 : tk - 32'd1;
                    rr_d     = (int'(gnt) == NUM_REQ-1) ? '0 : gnt + 1'b1;
                    state_d  = S_WP0;
                end
            end
            S_WP0:   state_d = S_WP1;
            S_WP1:   state_d = S_WP2;
            S_WP2:   state_d = S_WP3;
            S_WP3:   state_d = S_WCTL;
            S_WCTL:  state_d = S_WAIT;
            S_WAIT: begin
                if (tmr.irq)
                    state_d = S_CLR_D;
                else if (!req_i[owner_q])
                    state_d = S_WSTOP;
            end
            S_CLR_D: state_d = S_FIN_D;
            S_FIN_D: state_d = S_IDLE;
`ifdef TIMER_SCHED_REMAIN_EN
            S_WSTOP:  state_d = S_SNAPW;
            S_SNAPW:  state_d = S_SNAPR0;
            S_SNAPR0: state_d = S_SNAPR1;
            S_SNAPR1: state_d = S_SNAPC;
            S_SNAPC:  state_d = S_CLR_C;
`else
            S_WSTOP:  state_d = S_CLR_C;
`endif
            S_CLR_C: state_d = S_FIN_C;
            S_FIN_C: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus and pulse outputs decoded from the next state so they register with it
    always_comb begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = '0;
        wd_d   = '0;
        done_d = '0;
        canc_d = '0;
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_WP0:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd2; wd_d = period_d[15:0];  end
            S_WP1:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd3; wd_d = period_d[31:16]; end
            S_WP2:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd4; end
            S_WP3:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd5; end
            S_WCTL:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wd_d = 16'h0005; end
            S_CLR_D: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0; end
            S_WSTOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd1; wd_d = 16'h0008; end
            S_CLR_C: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd0; end
`ifdef TIMER_SCHED_REMAIN_EN
            S_SNAPW:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = 4'd6; end
            S_SNAPR0: begin cs_d = 1'b1; addr_d = 4'd6; end
            S_SNAPR1: begin cs_d = 1'b1; addr_d = 4'd7; end
`endif
            S_FIN_D: done_d[owner_d] = 1'b1;
            S_FIN_C: canc_d[owner_d] = 1'b1;
            default: ;
        endcase
    end

`ifdef TIMER_SCHED_REMAIN_EN
    // Snapshot capture: readdata lags the read address by one cycle
    always_comb begin
        rem_d = rem_q;
        if (state_q == S_SNAPR1) rem_d[15:0]  = tmr.readdata;
        if (state_q == S_SNAPC)  rem_d[31:16] = tmr.readdata;
    end

    // Remaining-count register, held until the next cancel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rem_q <= '0;
        else          rem_q <= rem_d;
    end

    assign remaining_o = rem_q;
`endif

    assign done_o         = done_q;
    assign cancelled_o    = canc_q;
    assign busy_o         = busy_q;
    assign owner_o        = owner_q;
    assign tmr.address    = addr_q;
    assign tmr.chipselect = cs_q;
    assign tmr.write_n    = wn_q;
    assign tmr.writedata  = wd_q;

endmodule

// File: tb/tb_timer_req_sched.sv
// Bench for timer_req_sched: behavioural interval-timer model, scoreboard
// of expected bus writes / pulses, and directed scenarios.
module tb_timer_req_sched;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [N-1:0]    req;
    logic [32*N-1:0] ticks;
    logic [N-1:0]    done_o, cancelled_o;
    logic            busy_o;
    logic [1:0]      owner_o;
`ifdef TIMER_SCHED_REMAIN_EN
    logic [31:0]     remaining_o;
`endif

    timer_req_sched_if bus ();

    timer_req_sched #(.NUM_REQ(N), .IDX_W(2)) dut (
        .clk(clk), .reset_n(reset_n), .req_i(req), .ticks_i(ticks),
        .done_o(done_o), .cancelled_o(cancelled_o), .busy_o(busy_o),
        .owner_o(owner_o), .tmr(bus)
`ifdef TIMER_SCHED_REMAIN_EN
        , .remaining_o(remaining_o)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- interval timer model ----------------
    logic [31:0] t_per, t_cnt, t_snap;
    logic        t_run, t_to, t_ito;
    logic [15:0] t_rd;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_per <= '0; t_cnt <= '0; t_snap <= '0;
            t_run <= 1'b0; t_to <= 1'b0; t_ito <= 1'b0; t_rd <= '0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin t_to <= 1'b1; t_run <= 1'b0; end
                else t_cnt <= t_cnt - 1;
            end
            if (bus.chipselect) begin
                if (!bus.write_n) begin
                    case (bus.address)
                        4'd0: t_to <= 1'b0;
                        4'd1: begin
                            t_ito <= bus.writedata[0];
                            if (bus.writedata[3]) t_run <= 1'b0;
                            else if (bus.writedata[2]) begin t_run <= 1'b1; t_cnt <= t_per; end
                        end
                        4'd2: t_per[15:0]  <= bus.writedata;
                        4'd3: t_per[31:16] <= bus.writedata;
                        4'd6: t_snap <= t_cnt;
                        default: ;
                    endcase
                end else begin
                    t_rd <= (bus.address == 4'd6) ? t_snap[15:0] :
                            (bus.address == 4'd7) ? t_snap[31:16] : 16'h0;
                end
            end
        end
    end

    assign bus.irq      = t_to & t_ito;
    assign bus.readdata = t_rd;

    // ---------------- scoreboard ----------------
    typedef struct { int idx; logic [31:0] tk; bit canc; } job_t;
    logic [19:0] exp_wr[$];
    logic [19:0] wlog[$];
    int          glog[$];
    job_t        exp_job[$];
    int          wctl_cyc = 0;
    int          model_rr = 0;
    int          vectors = 0, miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_to(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
    endtask

    // Expected bus traffic for one owned request, straight from the period rules
    task automatic push_job(input int idx, input logic [31:0] tk, input bit canc);
        logic [31:0] p;
        job_t j;
        p = (tk == 0) ? 32'd0 : tk - 32'd1;
        exp_wr.push_back({4'd2, p[15:0]});
        exp_wr.push_back({4'd3, p[31:16]});
        exp_wr.push_back({4'd4, 16'h0});
        exp_wr.push_back({4'd5, 16'h0});
        exp_wr.push_back({4'd1, 16'h0005});
        if (canc) begin
            exp_wr.push_back({4'd1, 16'h0008});
`ifdef TIMER_SCHED_REMAIN_EN
            exp_wr.push_back({4'd6, 16'h0});
`endif
        end
        exp_wr.push_back({4'd0, 16'h0});
        j.idx = idx; j.tk = tk; j.canc = canc;
        exp_job.push_back(j);
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic push_next(input logic [N-1:0] r, input logic [31:0] tk, input bit canc);
        int idx;
        idx = rr_pick(r, model_rr);
        model_rr = (idx + 1) % N;
        push_job(idx, tk, canc);
    endtask

    // Per-cycle compare of bus writes, owner and pulses against the scoreboard
    always @(negedge clk) begin
        job_t j;
        longint lat;
        if (reset_n) begin
            if (bus.chipselect && !bus.write_n) begin
                wlog.push_back({bus.address, bus.writedata});
                if (bus.address == 4'd2) glog.push_back(int'(owner_o));
                if (bus.address == 4'd1 && bus.writedata == 16'h0005) wctl_cyc = cyc;
                if (exp_wr.size() == 0) chk("unexpected_write", {bus.address, bus.writedata}, 20'hxxxxx);
                else chk("bus_write", {bus.address, bus.writedata}, exp_wr.pop_front());
            end
            if (busy_o && exp_job.size() != 0)
                chk("owner", owner_o, exp_job[0].idx);
            if ((done_o | cancelled_o) != 0) begin
                if (exp_job.size() == 0) begin
                    chk("unexpected_pulse", {done_o, cancelled_o}, 0);
                end else begin
                    j = exp_job.pop_front();
                    chk("done_vec", done_o, j.canc ? 0 : (1 << j.idx));
                    chk("cancel_vec", cancelled_o, j.canc ? (1 << j.idx) : 0);
                    if (!j.canc) begin
                        lat = (j.tk == 0) ? 4 : longint'(j.tk) + 3;
                        chk("done_latency", cyc - wctl_cyc, lat);
                    end
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_pulse(input int budget, output logic [N-1:0] d, output logic [N-1:0] c);
        d = '0; c = '0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if ((done_o | cancelled_o) != 0) begin
                d = done_o; c = cancelled_o;
                return;
            end
        end
        fail_to("pulse");
    endtask

    task automatic wait_wctl(input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (bus.chipselect && !bus.write_n && bus.address == 4'd1 && bus.writedata == 16'h0005)
                return;
        end
        fail_to("wctl");
    endtask

    task automatic chk_rst(input string nm);
        chk(nm, {done_o, cancelled_o, busy_o, owner_o, bus.address, bus.chipselect, bus.write_n, bus.writedata},
            {4'h0, 4'h0, 1'b0, 2'b00, 4'h0, 1'b0, 1'b1, 16'h0000});
`ifdef TIMER_SCHED_REMAIN_EN
        chk("rst_remaining", remaining_o, 0);
`endif
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        logic [N-1:0] d, c;
        int b, drop_cyc, n;
        int ord[8];
        bit seen;
        reset_n = 1'b0; req = '0; ticks = '0;
        repeat (3) @(negedge clk);
        chk_rst("reset_state");
        reset_n = 1'b1;
        @(negedge clk);

        // single request, ticks=100
        ticks[0 +: 32] = 32'd100;
        push_next(4'b0001, 32'd100, 0);
        b = wlog.size();
        req[0] = 1'b1;
        wait_pulse(400, d, c);
        chk("t1_done", d, 4'b0001);
        chk("t1_done_lat", cyc - wctl_cyc, 103);
        req[0] = 1'b0;
        @(negedge clk);
        chk("t1_done_one_cycle", done_o, 0);
        chk("t1_busy_fall", busy_o, 0);
        chk("t1_wr0", wlog[b+0], 20'h20063);
        chk("t1_wr1", wlog[b+1], 20'h30000);
        chk("t1_wr2", wlog[b+2], 20'h40000);
        chk("t1_wr3", wlog[b+3], 20'h50000);
        chk("t1_wr4", wlog[b+4], 20'h10005);
        chk("t1_wr5", wlog[b+5], 20'h00000);

        // ticks=0 on requester 1
        ticks[32 +: 32] = 32'd0;
        push_next(4'b0010, 32'd0, 0);
        b = wlog.size();
        req[1] = 1'b1;
        wait_pulse(100, d, c);
        chk("t2_done", d, 4'b0010);
        chk("t2_done_lat", cyc - wctl_cyc, 4);
        chk("t2_wp0", wlog[b+0], 20'h20000);
        chk("t2_wp1", wlog[b+1], 20'h30000);
        req[1] = 1'b0;
        repeat (2) @(negedge clk);

        // req[1] and req[3] together with rr_ptr=2
        ticks[32 +: 32] = 32'd5;
        ticks[96 +: 32] = 32'd5;
        push_next(4'b1010, 32'd5, 0);
        push_next(4'b0010, 32'd5, 0);
        b = glog.size();
        req[1] = 1'b1; req[3] = 1'b1;
        wait_pulse(100, d, c);
        chk("t3_first", d, 4'b1000);
        req[3] = 1'b0;
        wait_pulse(100, d, c);
        chk("t3_second", d, 4'b0010);
        req[1] = 1'b0;
        chk("t3_grant0", glog[b], 3);
        chk("t3_grant1", glog[b+1], 1);
        repeat (2) @(negedge clk);

        // all four held: strict rotation
        for (int k = 0; k < N; k++) ticks[32*k +: 32] = 32'd3;
        for (int k = 0; k < 8; k++) push_next(4'hF, 32'd3, 0);
        b = glog.size();
        req = 4'hF;
        for (int k = 0; k < 8; k++) begin
            wait_pulse(100, d, c);
            chk("t4_no_cancel", c, 0);
        end
        req = '0;
        ord = '{2, 3, 0, 1, 2, 3, 0, 1};
        for (int k = 0; k < 8; k++) chk("t4_grant_order", glog[b+k], ord[k]);
        repeat (2) @(negedge clk);
        chk("t4_idle", busy_o, 0);

        // cancel of requester 2 fifty cycles into WAIT
        ticks[64 +: 32] = 32'd1000;
        push_next(4'b0100, 32'd1000, 1);
        req[2] = 1'b1;
        wait_wctl(50);
        repeat (50) @(negedge clk);
        req[2] = 1'b0;
        drop_cyc = cyc;
        wait_pulse(50, d, c);
        chk("t5_cancelled", c, 4'b0100);
        chk("t5_no_done", d, 0);
`ifdef TIMER_SCHED_REMAIN_EN
        chk("t5_cancel_lat", cyc - drop_cyc, 7);
        chk("t5_remaining_range", (remaining_o >= 947 && remaining_o <= 951), 1);
`else
        chk("t5_cancel_lat", cyc - drop_cyc, 3);
`endif
        repeat (2) @(negedge clk);

        // ticks=0xFFFF_FFFF: period writes only, then cancel
        ticks[96 +: 32] = 32'hFFFF_FFFF;
        push_next(4'b1000, 32'hFFFF_FFFF, 1);
        b = wlog.size();
        req[3] = 1'b1;
        wait_wctl(50);
        repeat (3) @(negedge clk);
        req[3] = 1'b0;
        wait_pulse(50, d, c);
        chk("t6_cancelled", c, 4'b1000);
        chk("t6_wp0", wlog[b+0], 20'h2FFFE);
        chk("t6_wp1", wlog[b+1], 20'h3FFFF);
        repeat (2) @(negedge clk);

        // request drop in the very cycle irq rises: irq wins
        ticks[0 +: 32] = 32'd10;
        push_next(4'b0001, 32'd10, 0);
        req[0] = 1'b1;
        seen = 1'b0;
        for (n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (bus.irq) seen = 1'b1;
        end
        if (!seen) fail_to("t7_irq");
        req[0] = 1'b0;
        wait_pulse(20, d, c);
        chk("t7_done", d, 4'b0001);
        chk("t7_no_cancel_now", c, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t7_no_cancel_after", cancelled_o, 0);
        end

        // asynchronous reset while waiting on the timer
        ticks[64 +: 32] = 32'd1000;
        push_next(4'b0100, 32'd1000, 1);
        req[2] = 1'b1;
        wait_wctl(50);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        exp_wr.delete();
        exp_job.delete();
        req = '0;
        #1;
        chk_rst("t8_reset_immediate");
        repeat (2) begin
            @(negedge clk);
            chk_rst("t8_reset_hold");
        end
        reset_n = 1'b1;
        model_rr = 0;
        ticks[32 +: 32] = 32'd4;
        ticks[96 +: 32] = 32'd4;
        push_next(4'b1010, 32'd4, 0);
        push_next(4'b1000, 32'd4, 0);
        b = glog.size();
        req[1] = 1'b1; req[3] = 1'b1;
        wait_pulse(100, d, c);
        chk("t8_first_after_reset", d, 4'b0010);
        req[1] = 1'b0;
        wait_pulse(100, d, c);
        chk("t8_second_after_reset", d, 4'b1000);
        req[3] = 1'b0;
        chk("t8_grant0", glog[b], 1);
        chk("t8_grant1", glog[b+1], 3);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_wr.size() + exp_job.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/timer_req_sched.md
Name: timer_req_sched

Overview:
- Avalon-MM master that sole-owns one 64-bit interval timer (16-bit register slave, ports s1) and shares it among NUM_REQ one-shot timeout requesters.
- Round-robin arbitration picks a requester, programs the period registers, starts the timer, services its irq and returns a done pulse.
- Handles cancellation by stopping the timer and clearing status.
- Sits between the software-visible request logic and the timer instance in the Qsys system.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of owner index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock; same clock as the timer.
- reset_n  in  1  reset; asynchronous, active-low.
- req  in  NUM_REQ  per-requester level request; held high until done or cancel.
- ticks  in  32*NUM_REQ  requested timeout in clk cycles; slice i = ticks[32i+31:32i].
- done  out  NUM_REQ  one-cycle pulse to the owner on timeout.
- cancelled  out  NUM_REQ  one-cycle pulse to the owner after a cancel completes.
- busy  out  1  high whenever state is not IDLE.
- owner  out  IDX_W  index of the current owner; valid while busy.
- tmr_address  out  4  timer register address.
- tmr_chipselect  out  1  timer chipselect.
- tmr_write_n  out  1  active-low write.
- tmr_writedata  out  16  write data.
- tmr_readdata  in  16  timer read data; registered in the timer, valid the cycle after the address.
- tmr_irq  in  1  timer interrupt.

Behaviour:
- Reset:
  - All outputs 0, except tmr_write_n=1.
  - State IDLE; rr_ptr=0.
- Timer accesses:
  - A write takes one cycle (chipselect=1, write_n=0) and is always accepted.
  - A read drives address with chipselect=1, write_n=1, then samples tmr_readdata on the next cycle.
  - Outputs are registered; chipselect=0 in every state that issues no access.
- Arbitration (IDLE):
  - Grant the first i with req[i]=1, searching from rr_ptr upward with wrap.
  - On grant: owner<=i; latch ticks slice; rr_ptr<=i+1 (mod NUM_REQ). No grant means stay in IDLE.
- Period arithmetic:
  - The timer interval is period+1 cycles, so period = ticks-1.
  - ticks=0 is treated as 1 (period=0).
  - The period is zero-extended to 64 bits.
- FSM:
  - IDLE -> WP0 (addr 2, period[15:0]) -> WP1 (addr 3, period[31:16]) -> WP2 (addr 4, 0) -> WP3 (addr 5, 0) -> WCTL (addr 1, data 0x0005 = START|ITO, CONT=0) -> WAIT.
  - WAIT:
    - tmr_irq=1 -> CLR_D.
    - Else req[owner]=0 -> WSTOP.
  - CLR_D: addr 0, data 0 (clears TO) -> FIN_D. FIN_D pulses done[owner] -> IDLE.
  - WSTOP: addr 1, data 0x0008 (STOP, ITO=0) -> CLR_C. CLR_C: addr 0, data 0 -> FIN_C. FIN_C pulses cancelled[owner] -> IDLE.
- Latency:
  - Grant to timer start takes 6 cycles.
  - Timeout to done: irq rises 1 cycle after the counter reaches zero, done follows 2 cycles later.
- Simultaneous events and boundary conditions:
  - Same cycle in WAIT, irq=1 and req[owner]=0: irq wins, done is pulsed, no cancel.
  - req[owner] dropping during WP0..WCTL is ignored; the cancel is taken in WAIT.
  - A requester still high after done is re-eligible only via round-robin (it has the lowest priority next).
  - ticks changing while owned is ignored; the latched value is used.
- Reset mid-operation: FSM returns to IDLE asynchronously and no done/cancelled pulse is emitted. The timer shares reset_n, so no cleanup sequence is needed.

Optional Feature:
- Macro: TIMER_SCHED_REMAIN_EN.
- When defined:
  - Adds output remaining[31:0] and cancel path WSTOP -> SNAPW (write addr 6, data 0) -> SNAPR0 (read addr 6) -> SNAPR1 (read addr 7; capture [15:0]) -> SNAPC (capture [31:16]) -> CLR_C.
  - remaining is updated before cancelled pulses and holds until the next cancel.
  - Reset value is 0.
- When undefined: no remaining port and no snapshot states; cancel latency is 3 cycles.

Test Plan:
- Single req[0], ticks=100:
  - Exact write sequence on the bus: (2,0x0063), (3,0), (4,0), (5,0), (1,0x0005).
  - irq after 100 cycles, then (0,0) write, done[0] pulses one cycle, busy falls.
- req[1] and req[3] rise together, rr_ptr=2:
  - req[3] is served first, then req[1].
  - After that, with all of req[0..3] held: grant order 2,3,0,1 (and 0 before 1 in later rounds).
- ticks=0 and ticks=0xFFFF_FFFF:
  - ticks=0 writes period 0 and gives irq 1 cycle after start.
  - ticks=0xFFFF_FFFF writes 0xFFFE/0xFFFF (check WP writes only).
- req[2] dropped 50 cycles into WAIT with ticks=1000:
  - Writes (1,0x0008), (0,0); cancelled[2] pulses; no done.
  - With TIMER_SCHED_REMAIN_EN: remaining is 949±2.
- req[owner] drop in the same cycle tmr_irq rises: done pulses, cancelled stays 0.
- reset_n asserted while in WAIT: outputs go to reset values immediately, no pulses; next req is served from rr_ptr=0.
